// File: rtl/msg_schedule_pkg.sv
// Shared SHA-256 definitions: FSM state type, the round-constant table and
// the message-schedule sigma functions used by schedule and round logic.
package msg_schedule_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 16;
    localparam int ROUND_W   = 6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // SHA-256 round constants K[0..63] (first 32 bits of the fractional
    // parts of the cube roots of the first 64 primes).
    localparam logic [31:0] K_TABLE [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational lookup of the SHA-256 round constant for a round index.
module sha256_k_rom
    import msg_schedule_pkg::*;
(
    input  logic [5:0]  i_idx,
    output logic [31:0] o_k
);

    // Table lookup; every 6-bit index maps to a defined constant.
    always_comb begin
        o_k = K_TABLE[i_idx];
    end

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block, then emits W[t]/K[t]
// for t = 0..NUM_ROUNDS-1, advancing one round per in_en strobe. The 16-word
// window always holds W[t..t+15]; W[t+16] is formed as the window shifts.
module msg_schedule
    import msg_schedule_pkg::*;
#(
    parameter int NUM_ROUNDS = 64
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_start,
    input  logic [511:0] in_block,
    input  logic         in_en,
    output logic         out_ready,
    output logic         out_valid,
    output logic [31:0]  out_Wi,
    output logic [31:0]  out_Ki,
    output logic [5:0]   out_round,
    output logic         out_done
);

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_window [0:15];
    logic [5:0]  r_round;
    logic        r_done;

    logic        w_load;
    logic        w_advance;
    logic        w_last;
    logic [31:0] w_next_word;
    logic [31:0] w_k;

    // Round-constant lookup for the round currently presented.
    sha256_k_rom u_k_rom (
        .i_idx (r_round),
        .o_k   (w_k)
    );

    // Qualified load / advance strobes; requests outside their state are ignored.
    always_comb begin
        w_load    = (r_state == ST_IDLE) && in_start;
        w_advance = (r_state == ST_RUN) && in_en;
        w_last    = (r_round == LAST_ROUND);
    end

    // W[t+16] from the current window (window[i] = W[t+i]), mod 2^32.
    always_comb begin
        w_next_word = sigma1(r_window[14]) + r_window[9]
                    + sigma0(r_window[1]) + r_window[0];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic: IDLE -> RUN on load, RUN -> IDLE on the final advance.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_advance && w_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: driven only from registers, forced to zero outside RUN.
    always_comb begin
        out_ready = 1'b0;
        out_valid = 1'b0;
        out_Wi    = 32'h0000_0000;
        out_Ki    = 32'h0000_0000;
        out_round = 6'd0;
        case (r_state)
            ST_IDLE: begin
                out_ready = 1'b1;
            end
            ST_RUN: begin
                out_valid = 1'b1;
                out_Wi    = r_window[0];
                out_Ki    = w_k;
                out_round = r_round;
            end
            default: begin
                out_ready = 1'b0;
            end
        endcase
    end

    assign out_done = r_done;

    // Window: cleared on reset, loaded big-endian on start, shifted on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NUM_WORDS; j++) begin
                r_window[j] <= 32'h0000_0000;
            end
        end else if (w_load) begin
            for (int j = 0; j < NUM_WORDS; j++) begin
                r_window[j] <= in_block[511 - 32*j -: 32];
            end
        end else if (w_advance) begin
            for (int j = 0; j < NUM_WORDS - 1; j++) begin
                r_window[j] <= r_window[j + 1];
            end
            r_window[NUM_WORDS - 1] <= w_next_word;
        end
    end

    // Round counter and one-cycle done pulse after the final advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_round <= 6'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_advance && w_last;
            if (w_load) begin
                r_round <= 6'd0;
            end else if (w_advance) begin
                if (w_last) begin
                    r_round <= 6'd0;
                end else begin
                    r_round <= r_round + 6'd1;
                end
            end
        end
    end

endmodule

// File: doc/msg_schedule.md
MSG_SCHEDULE -- requirements
Module: msg_schedule

Interface
REQ-001 Parameter NUM_ROUNDS, default 64: number of (Wi, Ki) pairs emitted per block; legal range 16..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_start  input  1  block-load request; honoured only while out_ready=1.
REQ-005 in_block  input  512  padded message block; word j = in_block[511-32j -: 32], big-endian, j=0..15.
REQ-006 in_en  input  1  advance strobe from round controller; 0 = stall.
REQ-007 out_ready  output  1  1 only in IDLE.
REQ-008 out_valid  output  1  out_Wi/out_Ki/out_round valid.
REQ-009 out_Wi  output  32  schedule word W[t] for the compression round.
REQ-010 out_Ki  output  32  round constant K[t].
REQ-011 out_round  output  6  current round index t.
REQ-012 out_done  output  1  single-cycle pulse after last word consumed.

Function
REQ-013 States: IDLE, RUN; no other states reachable.
REQ-014 IDLE & in_start=1: capture 16 words into a 16x32 window, t=0, go RUN; out_valid=1 from the next cycle (start-to-W0 latency 1 cycle).
REQ-015 RUN: out_Wi = window[0] = W[t], out_Ki = K[t], out_round = t, out_valid=1; all driven from registers, no combinational path from in_en.
REQ-016 RUN & in_en=1: window shifts down by one, window[15] <= sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t] mod 2^32 (= W[t+16]); t <= t+1.
REQ-017 sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10; additions truncated to 32 bits, carries discarded.
REQ-018 RUN & in_en=0: window, t and all outputs held unchanged.
REQ-019 RUN & in_en=1 & t=NUM_ROUNDS-1: next cycle IDLE, out_valid=0, out_done=1 for exactly one cycle, out_ready=1.
REQ-020 in_start while RUN (including the final advance cycle): ignored, no state change.
REQ-021 IDLE & in_en=1: ignored.
REQ-022 Outside RUN, out_Wi, out_Ki, out_round = 0.
REQ-023 K[0..63] are the FIPS 180-4 SHA-256 constants, indexed by t.

Reset
REQ-024 rst=1 on a clock edge: state IDLE, t=0, window cleared, out_valid=0, out_done=0, out_Wi=0, out_Ki=0, out_round=0, out_ready=1.
REQ-025 rst overrides in_start and in_en in the same cycle; reset mid-RUN aborts the block without out_done.

Structure
REQ-026 The 64-entry K table and the sigma0/sigma1 definitions reside in a shared package used by both schedule and round logic.
REQ-027 One sub-module, sha256_k_rom (6-bit index in, 32-bit K out, combinational), is instantiated; window and FSM stay in msg_schedule.

Verification
REQ-028 Reset: hold rst 2 cycles -> out_ready=1, out_valid=0, out_done=0, out_Wi=out_Ki=out_round=0.
REQ-029 "abc" block (word0=0x61626380, words1-14=0, word15=0x00000018), in_en=1 continuous -> round0 Wi=0x61626380 Ki=0x428A2F98; round15 Wi=0x00000018; round16 Wi=0x61626380; round17 Wi=0x000F0000; round63 Ki=0xC67178F2; exactly 64 valid cycles then one out_done pulse.
REQ-030 Stall: "abc" block, in_en=0 for 3 cycles at round 20 -> Wi/Ki/round frozen for 3 cycles, resumes at round 20, 67 valid cycles total.
REQ-031 in_start pulsed with a different block at round 10 and at the final advance cycle -> sequence identical to REQ-029, out_ready stays 0 until after round 63.
REQ-032 rst asserted at round 30 -> next cycle IDLE, out_valid=0, no out_done; fresh start then reproduces REQ-029 from round 0.
REQ-033 All-zero block -> Wi=0 for all 64 rounds, Ki matches the K table, out_done pulses once.
